msk_lin_map_serial: RTL and testbench
=====================================

Name: msk_lin_map_serial

Overview:
- Sequential, byte-serial companion to the parallel masked linear-map stage.
- Accepts a full shared state through a valid/ready handshake and applies the per-share 8-bit basis change `lin_map` to BPC bytes per cycle.
- Returns the mapped shared state through a valid/ready handshake.
- Default instance applies the output (inverse) mapping, taking composite-field state back to the AES polynomial basis at the end of the datapath. It trades area for latency against the parallel version.

Parameters:
- d, 2, number of shares (≥2).
- count, 16, bytes per state.
- matrix_sel, 0, `lin_map` `MATRIX_SEL` value (0 = output/inverse mapping, 1 = input mapping).
- BPC, 4, bytes mapped per cycle; count must be a multiple of BPC.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  sh_state_in holds a state to map.
- in_ready  output  1  block can accept a state.
- sh_state_in  input  8*count*d  shared state, shbit encoding (bit b of share i at index b*d+i).
- out_valid  output  1  sh_state_out holds a mapped state.
- out_ready  input  1  consumer accepts sh_state_out.
- sh_state_out  output  8*count*d  mapped shared state, shbit encoding.

Behaviour:
- Encoding:
  - On capture, the input is converted to shblk (share i occupies bits [i*8*count +: 8*count]) and stored in a per-share buffer.
  - The output is converted back to shbit combinationally from that buffer.
- Mapping per share, per byte: out = M·in over GF(2). There is no share mixing and no randomness; recombining the output shares yields M·(XOR of input shares).
- FSM with states IDLE, BUSY, DONE.
- Reset (rst=1 at clock edge, any state):
  - state=IDLE, counter=0, buffer cleared to 0.
  - in_ready=0 during the reset cycle, then 1 in IDLE.
  - out_valid=0, sh_state_out=0.
  - A transfer in progress is discarded.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&in_ready: capture state, counter=0, go to BUSY.
- BUSY:
  - in_ready=0, out_valid=0.
  - Each cycle, bytes [counter*BPC, counter*BPC+BPC-1] of every share are replaced in the buffer by their mapped values. The byte index is LSB byte first.
  - counter increments each cycle.
  - When counter == count/BPC-1 the last group is written and the FSM goes to DONE.
- DONE:
  - out_valid=1, sh_state_out = buffer, in_ready=0.
  - On out_valid&out_ready, go to IDLE.
  - sh_state_out is held stable while out_valid=1 and out_ready=0.
- Latency: accept edge to out_valid high is exactly count/BPC cycles (4 with defaults).
- Throughput: one state per count/BPC+2 cycles minimum. There is no input/output overlap, to keep shares of consecutive states from coexisting in one register.
- in_valid asserted outside IDLE is ignored; the producer must hold it until in_ready.
- in_ready and out_valid are never both 1.
- Counter width: clog2(count/BPC), minimum 1 bit. It wraps to 0 on the DONE transition and is never read outside BUSY.
- BPC = count: a single BUSY cycle.

Decomposition:
- Shared package `msk_pkg`:
  - `shbit`/`shblk` index helper functions.
  - FSM state encoding constants (IDLE, BUSY, DONE).
  - clog2 function.
- Reuse existing `lin_map` (BPC*d instances), `shbit2shblk` and `shblk2shbit`.
- One natural new sub-module: `msk_lin_map_group`. It maps BPC bytes of all d shares combinationally and is instantiated once; `msk_lin_map_serial` holds the FSM, counter and buffer.

Test Plan:
- Reset mid-BUSY: accept a state, assert rst at cycle 2 -> next cycle state IDLE, out_valid=0, sh_state_out=0, in_ready=1 the cycle after rst drops; no later out_valid.
- All-zero state, out_ready=1 -> out_valid rises exactly 4 cycles after the accept edge (defaults), output all zeros, in_ready=1 the following cycle.
- Random shares with the unmasked byte sequence 0x00..0x0F -> the recombined output equals the `lin_map` model applied bytewise. Repeat with fresh random shares for the same secret: recombination is identical while individual output shares differ.
- Round trip: a matrix_sel=1 instance chained into a matrix_sel=0 instance, fed a random state -> recombined output equals the original unmasked state for 1000 random vectors, d=2 and d=3.
- Backpressure: out_ready=0 for 10 cycles in DONE -> sh_state_out stable, in_ready=0, new in_valid ignored; out_ready=1 -> handshake completes and the next state is accepted.
- BPC=16 and BPC=1 builds -> latency 1 and 16 cycles respectively, same outputs as the default build.

Source files
------------

// File: rtl/msk_pkg.sv
// msk_pkg: shared helpers for the masked datapath.
// Holds share-encoding index maps, FSM state codes and a constant clog2.
package msk_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // shbit: bit b of share i sits at b*d+i (shares interleaved per bit)
    function automatic int shbit_idx(input int b, input int i, input int d);
        return b * d + i;
    endfunction

    // shblk: share i occupies one contiguous block of n bits
    function automatic int shblk_idx(input int b, input int i, input int n);
        return i * n + b;
    endfunction

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/lin_map.sv
// lin_map: 8-bit GF(2) basis change applied at either end of the masked datapath.
// MATRIX_SEL=1 is the input mapping, MATRIX_SEL=0 its inverse (output mapping).
module lin_map #(
    parameter int MATRIX_SEL = 0
) (
    input  logic [7:0] x,
    output logic [7:0] y
);

    // input map multiplies by 1+t+t^3 in GF(2)[t]/(t^8); the output map by its inverse 1+t+t^2+t^4+t^7
    assign y = (MATRIX_SEL != 0) ? x ^ (x << 1) ^ (x << 3)
                                 : x ^ (x << 1) ^ (x << 2) ^ (x << 4) ^ (x << 7);

endmodule

// File: rtl/msk_lin_map_group.sv
// msk_lin_map_group: maps BPC bytes of every share combinationally.
// Share i occupies [i*8*BPC +: 8*BPC]; shares never mix, so each byte is mapped on its own.
module msk_lin_map_group #(
    parameter int d = 2,
    parameter int BPC = 4,
    parameter int matrix_sel = 0
) (
    input  logic [d*8*BPC-1:0] grp_in,
    output logic [d*8*BPC-1:0] grp_out
);

    for (genvar j = 0; j < d * BPC; j++) begin : g_byte
        lin_map #(.MATRIX_SEL(matrix_sel)) u_map (
            .x(grp_in[8*j +: 8]),
            .y(grp_out[8*j +: 8])
        );
    end

endmodule

// File: rtl/shbit2shblk.sv
// shbit2shblk: re-orders a bit-interleaved shared vector into per-share blocks.
module shbit2shblk
    import msk_pkg::*;
#(
    parameter int d = 2,
    parameter int count = 16
) (
    input  logic [8*count*d-1:0] shbit,
    output logic [8*count*d-1:0] shblk
);

    for (genvar b = 0; b < 8 * count; b++) begin : g_b
        for (genvar i = 0; i < d; i++) begin : g_i
            assign shblk[shblk_idx(b, i, 8 * count)] = shbit[shbit_idx(b, i, d)];
        end
    end

endmodule

// File: rtl/shblk2shbit.sv
// shblk2shbit: re-orders per-share blocks back into the bit-interleaved encoding.
module shblk2shbit
    import msk_pkg::*;
#(
    parameter int d = 2,
    parameter int count = 16
) (
    input  logic [8*count*d-1:0] shblk,
    output logic [8*count*d-1:0] shbit
);

    for (genvar b = 0; b < 8 * count; b++) begin : g_b
        for (genvar i = 0; i < d; i++) begin : g_i
            assign shbit[shbit_idx(b, i, d)] = shblk[shblk_idx(b, i, 8 * count)];
        end
    end

endmodule

// File: rtl/msk_lin_map_serial.sv
// msk_lin_map_serial: byte-serial masked linear map, BPC bytes of every share per cycle.
// Whole states in and out over valid/ready; input and output never overlap so shares of two states never share the buffer.
module msk_lin_map_serial
    import msk_pkg::*;
#(
    parameter int d = 2,
    parameter int count = 16,
    parameter int matrix_sel = 0,
    parameter int BPC = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8*count*d-1:0] sh_state_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*count*d-1:0] sh_state_out
);

    localparam int N = 8 * count;
    localparam int G = 8 * BPC;
    localparam int NG = count / BPC;
    localparam int CW = (clog2(NG) < 1) ? 1 : clog2(NG);
    localparam logic [CW-1:0] LAST = CW'(NG - 1);

    logic [1:0] state;
    logic [CW-1:0] cnt;
    logic [d*N-1:0] sh_buf;
    logic [d*N-1:0] blk_in;
    logic [d*G-1:0] grp_in;
    logic [d*G-1:0] grp_out;

    shbit2shblk #(.d(d), .count(count)) u_in (
        .shbit(sh_state_in),
        .shblk(blk_in)
    );

    shblk2shbit #(.d(d), .count(count)) u_out (
        .shblk(sh_buf),
        .shbit(sh_state_out)
    );

    msk_lin_map_group #(.d(d), .BPC(BPC), .matrix_sel(matrix_sel)) u_grp (
        .grp_in(grp_in),
        .grp_out(grp_out)
    );

    for (genvar i = 0; i < d; i++) begin : g_sel
        assign grp_in[i*G +: G] = sh_buf[i*N + int'(cnt)*G +: G];
    end

    assign in_ready = (state == ST_IDLE) && !rst;
    assign out_valid = state == ST_DONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt <= '0;
            sh_buf <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        sh_buf <= blk_in;
                        cnt <= '0;
                        state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    for (int i = 0; i < d; i++) sh_buf[i*N + int'(cnt)*G +: G] <= grp_out[i*G +: G];
                    cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
                    if (cnt == LAST) state <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_msk_lin_map_serial.sv
// tb_msk_lin_map_serial: directed checks of the serial masked linear map (BPC 4/16/1) and inverse-map round trips.
module tb_msk_lin_map_serial;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic [255:0] sh_in = '0;
    logic rdy0, rdy1, rdy2, ov0, ov1, ov2;
    logic [255:0] so0, so1, so2;

    logic c2_valid = 1'b0;
    logic c2_rdy, m2_valid, m2_rdy, c2_ov;
    logic [255:0] c2_in = '0;
    logic [255:0] m2_st, c2_out;
    logic c3_valid = 1'b0;
    logic c3_rdy, m3_valid, m3_rdy, c3_ov;
    logic [383:0] c3_in = '0;
    logic [383:0] m3_st, c3_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    msk_lin_map_serial #(.d(2), .count(16), .matrix_sel(0), .BPC(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .sh_state_in(sh_in),
        .out_valid(ov0), .out_ready(out_ready), .sh_state_out(so0)
    );
    msk_lin_map_serial #(.d(2), .count(16), .matrix_sel(0), .BPC(16)) u16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .sh_state_in(sh_in),
        .out_valid(ov1), .out_ready(out_ready), .sh_state_out(so1)
    );
    msk_lin_map_serial #(.d(2), .count(16), .matrix_sel(0), .BPC(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2), .sh_state_in(sh_in),
        .out_valid(ov2), .out_ready(out_ready), .sh_state_out(so2)
    );

    msk_lin_map_serial #(.d(2), .count(16), .matrix_sel(1), .BPC(4)) ca2 (
        .clk(clk), .rst(rst), .in_valid(c2_valid), .in_ready(c2_rdy), .sh_state_in(c2_in),
        .out_valid(m2_valid), .out_ready(m2_rdy), .sh_state_out(m2_st)
    );
    msk_lin_map_serial #(.d(2), .count(16), .matrix_sel(0), .BPC(4)) cb2 (
        .clk(clk), .rst(rst), .in_valid(m2_valid), .in_ready(m2_rdy), .sh_state_in(m2_st),
        .out_valid(c2_ov), .out_ready(1'b1), .sh_state_out(c2_out)
    );
    msk_lin_map_serial #(.d(3), .count(16), .matrix_sel(1), .BPC(4)) ca3 (
        .clk(clk), .rst(rst), .in_valid(c3_valid), .in_ready(c3_rdy), .sh_state_in(c3_in),
        .out_valid(m3_valid), .out_ready(m3_rdy), .sh_state_out(m3_st)
    );
    msk_lin_map_serial #(.d(3), .count(16), .matrix_sel(0), .BPC(4)) cb3 (
        .clk(clk), .rst(rst), .in_valid(m3_valid), .in_ready(m3_rdy), .sh_state_in(m3_st),
        .out_valid(c3_ov), .out_ready(1'b1), .sh_state_out(c3_out)
    );

    function automatic logic [383:0] mask(input logic [127:0] x, input int dd);
        logic [383:0] s;
        logic acc;
        s = '0;
        for (int b = 0; b < 128; b++) begin
            acc = x[b];
            for (int i = 0; i < dd - 1; i++) begin
                s[b*dd+i] = ($urandom() % 2) == 1;
                acc = acc ^ s[b*dd+i];
            end
            s[b*dd+dd-1] = acc;
        end
        return s;
    endfunction

    function automatic logic [127:0] unmask(input logic [383:0] s, input int dd);
        logic [127:0] x;
        x = '0;
        for (int b = 0; b < 128; b++)
            for (int i = 0; i < dd; i++) x[b] = x[b] ^ s[b*dd+i];
        return x;
    endfunction

    // output map as multiplication by 0x97 (1+t+t^2+t^4+t^7) truncated mod t^8, bytewise
    function automatic logic [127:0] mapst(input logic [127:0] x);
        logic [7:0] p, v, y;
        logic [127:0] r;
        p = 8'h97;
        r = '0;
        for (int k = 0; k < 16; k++) begin
            v = x[8*k +: 8];
            y = '0;
            for (int j = 0; j < 8; j++) if (p[j]) y = y ^ (v << j);
            r[8*k +: 8] = y;
        end
        return r;
    endfunction

    task automatic send(input logic [255:0] st);
        int t;
        t = 0;
        sh_in = st;
        in_valid = 1'b1;
        while (!(rdy0 && rdy1 && rdy2) && t < 20) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if ({rdy0, rdy1, rdy2} !== 3'b111) begin
            errors++;
            $display("FAIL send_ready: got %b%b%b want 111", rdy0, rdy1, rdy2);
        end
        @(posedge clk);
    endtask

    // k counts clock edges after the accept edge
    task automatic collect(output logic [255:0] o0, output logic [255:0] o1, output logic [255:0] o2,
                           output int l0, output int l1, output int l2, output logic ra);
        l0 = -1; l1 = -1; l2 = -1; ra = 1'b0;
        o0 = '0; o1 = '0; o2 = '0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k == 0) in_valid = 1'b0;
            if (ov0 && l0 < 0) begin l0 = k; o0 = so0; end
            if (ov1 && l1 < 0) begin l1 = k; o1 = so1; end
            if (ov2 && l2 < 0) begin l2 = k; o2 = so2; end
            if (l0 >= 0 && k == l0 + 1) ra = rdy0;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({rdy0, rdy1, rdy2} !== 3'b000) begin errors++; $display("FAIL reset_in_ready: got %b%b%b want 000", rdy0, rdy1, rdy2); end
        checks++;
        if ({ov0, ov1, ov2} !== 3'b000) begin errors++; $display("FAIL reset_out_valid: got %b%b%b want 000", ov0, ov1, ov2); end
        checks++;
        if (so0 !== '0) begin errors++; $display("FAIL reset_out: got %h want 0", so0); end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({rdy0, rdy1, rdy2} !== 3'b111) begin errors++; $display("FAIL idle_in_ready: got %b%b%b want 111", rdy0, rdy1, rdy2); end
    endtask

    task automatic test_zero;
        logic [255:0] o0, o1, o2;
        int l0, l1, l2;
        logic ra;
        out_ready = 1'b1;
        send('0);
        collect(o0, o1, o2, l0, l1, l2, ra);
        checks++;
        if (l0 !== 4) begin errors++; $display("FAIL zero_latency: got %0d want 4", l0); end
        checks++;
        if (o0 !== '0) begin errors++; $display("FAIL zero_out: got %h want 0", o0); end
        checks++;
        if (ra !== 1'b1) begin errors++; $display("FAIL zero_ready_after: got %b want 1", ra); end
    endtask

    task automatic test_sequence;
        logic [127:0] sec, exp, u;
        logic [383:0] m;
        logic [255:0] o0, o1, o2, first;
        int l0, l1, l2;
        logic ra;
        for (int k = 0; k < 16; k++) sec[8*k +: 8] = 8'(k);
        exp = mapst(sec);
        m = mask(sec, 2);
        send(m[255:0]);
        collect(o0, o1, o2, l0, l1, l2, ra);
        u = unmask({128'h0, o0}, 2);
        checks++;
        if (u !== exp) begin errors++; $display("FAIL seq_recombine: got %h want %h", u, exp); end
        checks++;
        if (u[15:8] !== 8'h97) begin errors++; $display("FAIL seq_byte1: got %h want 97", u[15:8]); end
        checks++;
        if (u[127:120] !== 8'h5D) begin errors++; $display("FAIL seq_byte15: got %h want 5d", u[127:120]); end
        checks++;
        if (l1 !== 1) begin errors++; $display("FAIL bpc16_latency: got %0d want 1", l1); end
        checks++;
        if (l2 !== 16) begin errors++; $display("FAIL bpc1_latency: got %0d want 16", l2); end
        checks++;
        if (o1 !== o0) begin errors++; $display("FAIL bpc16_out: got %h want %h", o1, o0); end
        checks++;
        if (o2 !== o0) begin errors++; $display("FAIL bpc1_out: got %h want %h", o2, o0); end
        first = o0;
        m = mask(sec, 2);
        send(m[255:0]);
        collect(o0, o1, o2, l0, l1, l2, ra);
        u = unmask({128'h0, o0}, 2);
        checks++;
        if (u !== exp) begin errors++; $display("FAIL reseq_recombine: got %h want %h", u, exp); end
        checks++;
        if (o0 === first) begin errors++; $display("FAIL reseq_shares_differ: got %h want anything but %h", o0, first); end
    endtask

    task automatic test_backpressure;
        logic [127:0] sa, sb, u;
        logic [383:0] ma, mb;
        logic [255:0] o0, o1, o2;
        int l0, l1, l2;
        logic ra;
        sa = {$urandom(), $urandom(), $urandom(), $urandom()};
        sb = {$urandom(), $urandom(), $urandom(), $urandom()};
        ma = mask(sa, 2);
        mb = mask(sb, 2);
        out_ready = 1'b0;
        send(ma[255:0]);
        collect(o0, o1, o2, l0, l1, l2, ra);
        u = unmask({128'h0, o0}, 2);
        checks++;
        if (u !== mapst(sa)) begin errors++; $display("FAIL bp_first_out: got %h want %h", u, mapst(sa)); end
        sh_in = mb[255:0];
        in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++;
            if (ov0 !== 1'b1) begin errors++; $display("FAIL bp_hold_valid cycle %0d: got %b want 1", k, ov0); end
            checks++;
            if (rdy0 !== 1'b0) begin errors++; $display("FAIL bp_hold_ready cycle %0d: got %b want 0", k, rdy0); end
            checks++;
            if (so0 !== o0) begin errors++; $display("FAIL bp_hold_stable cycle %0d: got %h want %h", k, so0, o0); end
        end
        out_ready = 1'b1;
        send(mb[255:0]);
        collect(o0, o1, o2, l0, l1, l2, ra);
        u = unmask({128'h0, o0}, 2);
        checks++;
        if (u !== mapst(sb)) begin errors++; $display("FAIL bp_next_out: got %h want %h", u, mapst(sb)); end
        checks++;
        if (l0 !== 4) begin errors++; $display("FAIL bp_next_latency: got %0d want 4", l0); end
    endtask

    task automatic test_reset_mid_busy;
        logic [383:0] m;
        logic seen;
        m = mask(128'hFFEEDDCCBBAA99887766554433221100, 2);
        out_ready = 1'b1;
        send(m[255:0]);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (ov0 !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", ov0); end
        checks++;
        if (so0 !== '0) begin errors++; $display("FAIL midrst_out: got %h want 0", so0); end
        checks++;
        if (rdy0 !== 1'b0) begin errors++; $display("FAIL midrst_ready_in_reset: got %b want 0", rdy0); end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (rdy0 !== 1'b1) begin errors++; $display("FAIL midrst_ready_after: got %b want 1", rdy0); end
        seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (ov0 || ov1 || ov2) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL midrst_no_output: got %b want 0", seen); end
    endtask

    task automatic test_round_trip;
        logic [127:0] sec, u2, u3;
        logic [383:0] t2, t3, r3;
        logic [255:0] r2;
        logic got2, got3, pend2, pend3;
        for (int n = 0; n < 1000; n++) begin
            sec = {$urandom(), $urandom(), $urandom(), $urandom()};
            t2 = mask(sec, 2);
            t3 = mask(sec, 3);
            c2_in = t2[255:0];
            c3_in = t3;
            c2_valid = 1'b1;
            c3_valid = 1'b1;
            got2 = 1'b0; got3 = 1'b0; pend2 = 1'b0; pend3 = 1'b0;
            r2 = '0; r3 = '0;
            for (int k = 0; k < 60 && !(got2 && got3); k++) begin
                if (pend2) c2_valid = 1'b0; else if (c2_valid && c2_rdy) pend2 = 1'b1;
                if (pend3) c3_valid = 1'b0; else if (c3_valid && c3_rdy) pend3 = 1'b1;
                if (c2_ov && !got2) begin got2 = 1'b1; r2 = c2_out; end
                if (c3_ov && !got3) begin got3 = 1'b1; r3 = c3_out; end
                @(negedge clk);
            end
            c2_valid = 1'b0;
            c3_valid = 1'b0;
            u2 = unmask({128'h0, r2}, 2);
            u3 = unmask(r3, 3);
            checks++;
            if (!got2 || u2 !== sec) begin errors++; $display("FAIL rt_d2 vec %0d: got %h (valid %b) want %h", n, u2, got2, sec); end
            checks++;
            if (!got3 || u3 !== sec) begin errors++; $display("FAIL rt_d3 vec %0d: got %h (valid %b) want %h", n, u3, got3, sec); end
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_sequence();
        test_backpressure();
        test_reset_mid_busy();
        test_round_trip();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
